// File: rtl/ara_vid_allocator.sv
// Vector-instruction ID allocator: grants free IDs, tracks per-PE running state,
// retires IDs when every target PE reports done, and reports the oldest running ID.
module ara_vid_allocator #(
  parameter  int unsigned NrLanes = 4,
  parameter  int unsigned NrVInsn = 8,
  localparam int unsigned NrPEs   = NrLanes + 4,
  localparam int unsigned IdW     = $clog2(NrVInsn)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alloc_req_i,
  input  logic [NrPEs-1:0]         alloc_pe_mask_i,
  output logic                     alloc_gnt_o,
  output logic [IdW-1:0]           alloc_vid_o,
  input  logic [NrPEs*NrVInsn-1:0] pe_done_i,
  output logic [NrPEs*NrVInsn-1:0] pe_vinsn_running_o,
  output logic [NrVInsn-1:0]       vinsn_running_o,
  output logic [IdW:0]             num_running_o,
  output logic                     full_o,
  output logic                     idle_o,
  output logic                     oldest_valid_o,
  output logic [IdW-1:0]           oldest_vid_o,
  output logic                     error_o
);

  typedef logic [NrPEs-1:0][NrVInsn-1:0]   pe_map_t;
  typedef logic [NrVInsn-1:0][NrVInsn-1:0] age_t;

  pe_map_t r_pe_running, w_pe_running_d, w_pe_done;
  age_t    r_age, w_age_d, w_age_t;
  logic    r_error;

  logic [NrVInsn-1:0] w_vinsn_running;
  logic [IdW:0]       w_num_running;
  logic [IdW-1:0]     w_alloc_vid, w_oldest_vid;
  logic               w_full, w_idle, w_gnt, w_bad_done, w_oldest_valid;

  assign w_pe_done = pe_done_i;

  // NOTE: every variable written in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_vinsn_running = '0;
    w_num_running   = '0;
    for (int p = 0; p < int'(NrPEs); p++) w_vinsn_running |= r_pe_running[p];
    for (int v = 0; v < int'(NrVInsn); v++)
      w_num_running = w_num_running + {{IdW{1'b0}}, w_vinsn_running[v]};
  end

  assign w_full = &w_vinsn_running;
  assign w_idle = ~|w_vinsn_running;
  assign w_gnt  = alloc_req_i & ~w_full & (|alloc_pe_mask_i);

  // Lowest-index free ID; scanning downward lets the lowest hit win.
  always_comb begin
    w_alloc_vid = '0;
    for (int v = int'(NrVInsn) - 1; v >= 0; v--)
      if (!w_vinsn_running[v]) w_alloc_vid = IdW'(v);
  end

  // Row i of the transpose lists every ID j recorded as older than i.
  always_comb begin
    w_age_t = '0;
    for (int i = 0; i < int'(NrVInsn); i++)
      for (int j = 0; j < int'(NrVInsn); j++) w_age_t[i][j] = r_age[j][i];
  end

  always_comb begin
    w_oldest_valid = 1'b0;
    w_oldest_vid   = '0;
    for (int i = int'(NrVInsn) - 1; i >= 0; i--)
      if (w_vinsn_running[i] && !(|(w_vinsn_running & w_age_t[i]))) begin
        w_oldest_valid = 1'b1;
        w_oldest_vid   = IdW'(i);
      end
  end

  assign w_bad_done = |(w_pe_done & ~r_pe_running);

  // Dones clear first; a grant then overwrites the (free, hence empty) column of the new ID.
  always_comb begin
    w_pe_running_d = r_pe_running & ~w_pe_done;
    w_age_d        = r_age;
    if (w_gnt) begin
      for (int p = 0; p < int'(NrPEs); p++) w_pe_running_d[p][w_alloc_vid] = alloc_pe_mask_i[p];
      w_age_d[w_alloc_vid] = '0;
      for (int i = 0; i < int'(NrVInsn); i++) w_age_d[i][w_alloc_vid] = w_vinsn_running[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pe_running <= '0;
      // NOTE: the age matrix is a small flop array and is cleared on reset so the
      // block leaves reset in a fully defined state; entries of free IDs are masked anyway.
      r_age        <= '0;
      r_error      <= 1'b0;
    end else begin
      r_pe_running <= w_pe_running_d;
      r_age        <= w_age_d;
      r_error      <= r_error | w_bad_done;
    end
  end

  assign alloc_gnt_o        = w_gnt;
  assign alloc_vid_o        = w_alloc_vid;
  assign pe_vinsn_running_o = r_pe_running;
  assign vinsn_running_o    = w_vinsn_running;
  assign num_running_o      = w_num_running;
  assign full_o             = w_full;
  assign idle_o             = w_idle;
  assign oldest_valid_o     = w_oldest_valid;
  assign oldest_vid_o       = w_oldest_vid;
  assign error_o            = r_error;

endmodule

// File: tb/tb_ara_vid_allocator.sv
// Self-checking bench for ara_vid_allocator: directed table, hand-written corner
// sequences and random traffic against an ID-set / allocation-order reference model.
module tb_ara_vid_allocator;

  localparam int NP = 8;
  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req;
  logic [7:0]  mask;
  logic [63:0] done;
  logic        gnt;
  logic [2:0]  vid;
  logic [63:0] pe_running;
  logic [7:0]  running;
  logic [3:0]  num;
  logic        full, idle, oldest_valid, error;
  logic [2:0]  oldest_vid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ara_vid_allocator #(.NrLanes(4), .NrVInsn(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alloc_req_i(req), .alloc_pe_mask_i(mask),
    .alloc_gnt_o(gnt), .alloc_vid_o(vid),
    .pe_done_i(done), .pe_vinsn_running_o(pe_running),
    .vinsn_running_o(running), .num_running_o(num),
    .full_o(full), .idle_o(idle),
    .oldest_valid_o(oldest_valid), .oldest_vid_o(oldest_vid),
    .error_o(error)
  );

  // Reference model: set of PEs still busy per ID, plus IDs in allocation order.
  bit [7:0] m_pes [NV];
  int       m_order[$];
  bit       m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dbit(input int p, input int v);
    logic [63:0] one;
    one = 64'd1;
    return one << (p * NV + v);
  endfunction

  function automatic bit [7:0] m_running();
    bit [7:0] r;
    for (int v = 0; v < NV; v++) r[v] = (m_pes[v] != 8'd0);
    return r;
  endfunction

  function automatic int m_lowest_free();
    for (int v = 0; v < NV; v++) if (m_pes[v] == 8'd0) return v;
    return 0;
  endfunction

  function automatic bit m_grant();
    return req && (mask != 8'd0) && (m_running() != 8'hFF);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_pes[v] = 8'd0;
    m_order.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step();
    bit g;
    int k;
    int keep[$];
    g = m_grant();
    k = m_lowest_free();
    for (int p = 0; p < NP; p++)
      for (int v = 0; v < NV; v++)
        if (done[p*NV+v]) begin
          if (m_pes[v][p]) m_pes[v][p] = 1'b0;
          else m_err = 1'b1;
        end
    if (g) begin
      m_pes[k] = mask;
      m_order.push_back(k);
    end
    foreach (m_order[i]) if (m_pes[m_order[i]] != 8'd0) keep.push_back(m_order[i]);
    m_order = keep;
  endtask

  task automatic compare_all();
    bit [7:0]    r;
    logic [63:0] pe;
    bit          g;
    r = m_running();
    g = m_grant();
    for (int p = 0; p < NP; p++)
      for (int v = 0; v < NV; v++) pe[p*NV+v] = m_pes[v][p];
    check("alloc_gnt", 64'(gnt), 64'(g));
    if (g) check("alloc_vid", 64'(vid), 64'(m_lowest_free()));
    check("vinsn_running", 64'(running), 64'(r));
    check("pe_vinsn_running", pe_running, pe);
    check("num_running", 64'(num), 64'($countones(r)));
    check("full", 64'(full), 64'(r == 8'hFF));
    check("idle", 64'(idle), 64'(r == 8'h00));
    check("oldest_valid", 64'(oldest_valid), 64'(m_order.size() > 0));
    check("oldest_vid", 64'(oldest_vid), 64'(m_order.size() > 0 ? m_order[0] : 0));
    check("error", 64'(error), 64'(m_err));
  endtask

  // Drive inputs, then compare at the falling edge against the pre-edge model state.
  task automatic begin_cycle(input logic r, input logic [7:0] m, input logic [63:0] d);
    req = r; mask = m; done = d;
    @(negedge clk);
    compare_all();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(input logic r, input logic [7:0] m, input logic [63:0] d);
    begin_cycle(r, m, d);
    end_cycle();
  endtask

  task automatic do_reset();
    req = 1'b0; mask = 8'd0; done = 64'd0;
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_idle", 64'(idle), 64'd1);
    @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  typedef struct {
    logic        req;
    logic [7:0]  mask;
    logic [63:0] done;
    logic        exp_gnt;
    logic [2:0]  exp_vid;
    logic [7:0]  exp_running;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [63:0] d;
    logic [7:0]  mk;

    // Fill, grant-to-full, blocked requests, and ID 2 retiring over two dones three cycles apart.
    tbl[0]  = '{1'b1, 8'h00, 64'd0,     1'b0, 3'd0, 8'h00};
    tbl[1]  = '{1'b1, 8'h0F, 64'd0,     1'b1, 3'd0, 8'h00};
    tbl[2]  = '{1'b1, 8'h10, 64'd0,     1'b1, 3'd1, 8'h01};
    tbl[3]  = '{1'b1, 8'h03, 64'd0,     1'b1, 3'd2, 8'h03};
    tbl[4]  = '{1'b1, 8'h20, 64'd0,     1'b1, 3'd3, 8'h07};
    tbl[5]  = '{1'b1, 8'h40, 64'd0,     1'b1, 3'd4, 8'h0F};
    tbl[6]  = '{1'b1, 8'h80, 64'd0,     1'b1, 3'd5, 8'h1F};
    tbl[7]  = '{1'b1, 8'h01, 64'd0,     1'b1, 3'd6, 8'h3F};
    tbl[8]  = '{1'b1, 8'h02, 64'd0,     1'b1, 3'd7, 8'h7F};
    tbl[9]  = '{1'b1, 8'hFF, 64'd0,     1'b0, 3'd0, 8'hFF};
    tbl[10] = '{1'b1, 8'hFF, dbit(0,2), 1'b0, 3'd0, 8'hFF};
    tbl[11] = '{1'b1, 8'hFF, 64'd0,     1'b0, 3'd0, 8'hFF};
    tbl[12] = '{1'b1, 8'hFF, 64'd0,     1'b0, 3'd0, 8'hFF};
    tbl[13] = '{1'b1, 8'hFF, dbit(1,2), 1'b0, 3'd0, 8'hFF};
    tbl[14] = '{1'b1, 8'h04, 64'd0,     1'b1, 3'd2, 8'hFB};
    tbl[15] = '{1'b0, 8'h00, 64'd0,     1'b0, 3'd0, 8'hFF};

    req = 1'b0; mask = 8'd0; done = 64'd0; rst_ni = 1'b0;
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      begin_cycle(tbl[i].req, tbl[i].mask, tbl[i].done);
      check($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].exp_gnt));
      if (tbl[i].exp_gnt) check($sformatf("tbl%0d_vid", i), 64'(vid), 64'(tbl[i].exp_vid));
      check($sformatf("tbl%0d_running", i), 64'(running), 64'(tbl[i].exp_running));
      if (i == 2) begin
        check("t1_pe_running", pe_running, 64'h0000_0000_0101_0101);
        check("t1_num", 64'(num), 64'd1);
        check("t1_oldest", 64'(oldest_vid), 64'd0);
      end
      if (i == 9) check("t2_full", 64'(full), 64'd1);
      end_cycle();
    end

    // Mid-run reset drops every ID; the next request gets ID 0.
    do_reset();
    begin_cycle(1'b1, 8'h01, 64'd0);
    check("t6_vid_after_reset", 64'(vid), 64'd0);
    check("t6_gnt_after_reset", 64'(gnt), 64'd1);
    end_cycle();

    // Out-of-order retirement: allocate 0,1,2; retire 1, then 0, then 2.
    do_reset();
    cycle(1'b1, 8'h01, 64'd0);
    cycle(1'b1, 8'h02, 64'd0);
    cycle(1'b1, 8'h04, 64'd0);
    begin_cycle(1'b0, 8'h00, dbit(1,1));
    check("t4_oldest_a", 64'(oldest_vid), 64'd0);
    end_cycle();
    begin_cycle(1'b0, 8'h00, dbit(0,0));
    check("t4_oldest_b", 64'(oldest_vid), 64'd0);
    end_cycle();
    begin_cycle(1'b0, 8'h00, dbit(2,2));
    check("t4_oldest_c", 64'(oldest_vid), 64'd2);
    end_cycle();
    begin_cycle(1'b0, 8'h00, 64'd0);
    check("t4_oldest_valid", 64'(oldest_valid), 64'd0);
    end_cycle();

    // Grant in the same cycle the oldest retires: the new ID becomes the sole oldest.
    cycle(1'b1, 8'h01, 64'd0);
    begin_cycle(1'b1, 8'h03, dbit(0,0));
    check("gr_vid", 64'(vid), 64'd1);
    end_cycle();
    begin_cycle(1'b0, 8'h00, 64'd0);
    check("gr_running", 64'(running), 64'h02);
    check("gr_oldest", 64'(oldest_vid), 64'd1);
    end_cycle();
    cycle(1'b0, 8'h00, dbit(0,1) | dbit(1,1));

    // Spurious done: error sets and sticks, bitmaps untouched, cleared only by reset.
    cycle(1'b1, 8'h01, 64'd0);
    begin_cycle(1'b0, 8'h00, dbit(5,3));
    check("t5_error_before", 64'(error), 64'd0);
    end_cycle();
    begin_cycle(1'b0, 8'h00, 64'd0);
    check("t5_error", 64'(error), 64'd1);
    check("t5_running", 64'(running), 64'h01);
    end_cycle();
    repeat (3) cycle(1'b0, 8'h00, 64'd0);
    begin_cycle(1'b0, 8'h00, 64'd0);
    check("t5_error_sticky", 64'(error), 64'd1);
    end_cycle();
    do_reset();
    begin_cycle(1'b0, 8'h00, 64'd0);
    check("t5_error_cleared", 64'(error), 64'd0);
    end_cycle();

    // Random traffic against the model; one mid-run reset, spurious dones only afterwards.
    for (int i = 0; i < 2000; i++) begin
      if (i == 900) do_reset();
      d = 64'd0;
      for (int p = 0; p < NP; p++)
        for (int v = 0; v < NV; v++)
          if (m_pes[v][p] && $urandom_range(0, 2) == 0) d = d | dbit(p, v);
      if (i > 1200 && $urandom_range(0, 199) == 0) d = d | dbit($urandom_range(0, 7), $urandom_range(0, 7));
      mk = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      cycle($urandom_range(0, 3) != 0, mk, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
